sa9_stream_fifo: RTL and testbench

Leaf buffering stage placed alongside the `sa9_*` leaves of the `sa8_3` subtree. It decouples a producer leaf from a consumer leaf with a valid/ready FIFO. It also keeps two running statistics for tree-level checking: a pop counter and an XOR checksum of accepted words. It registers all state and has no combinational path from `in_*` to `out_*`.

---
 rtl/sa9_stream_fifo.sv | 72 +++++++
 tb/tb_sa9_stream_fifo.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sa9_stream_fifo.sv
`default_nettype none
// ==== sa9_stream_fifo : registered valid/ready FIFO with pop counter and XOR checksum ====
// ==== rev 1.0                                                                         ====
module sa9_stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CW-1:0]            pop_cnt,
  output logic [WIDTH-1:0]         csum
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam logic [NW-1:0] FULL_COUNT = NW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [NW-1:0]    occ;
  logic             push;
  logic             pop;

  // Handshakes decode from registered occupancy only, so no in_* to out_* path exists.
  assign in_ready  = (occ != FULL_COUNT);
  assign out_valid = (occ != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign count     = occ;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      pop_cnt <= '0;
      csum    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        csum   <= csum ^ in_data;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        pop_cnt <= pop_cnt + CW'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + NW'(1);
        2'b01:   occ <= occ - NW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sa9_stream_fifo.sv
`default_nettype none
// ==== tb_sa9_stream_fifo : scoreboard bench for sa9_stream_fifo (DEPTH=4, CW=4) ====
// ==== rev 1.0                                                                    ====
module tb_sa9_stream_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       count;
  logic [CW-1:0]    pop_cnt;
  logic [WIDTH-1:0] csum;

  sa9_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .pop_cnt(pop_cnt), .csum(csum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] sb[$];
  int               m_count;
  logic [CW-1:0]    m_pop;
  logic [WIDTH-1:0] m_csum;
  logic [WIDTH-1:0] last_popped;
  bit               wrap_seen;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(m_count));
    chk({tag, "_csum"}, 32'(csum), 32'(m_csum));
    chk({tag, "_pop_cnt"}, 32'(pop_cnt), 32'(m_pop));
  endtask

  // Called at #1 after an edge: checks head/handshakes, drives, steps one edge, updates model.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic r, input string tag);
    bit exp_push, exp_pop;
    exp_push = v && (m_count != DEPTH);
    exp_pop  = r && (m_count != 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(m_count != DEPTH));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(m_count != 0));
    chk({tag, "_out_data"}, 32'(out_data), (m_count != 0) ? 32'(sb[0]) : 32'h0);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
    if (exp_pop) begin
      last_popped = sb.pop_front();
      if (m_pop == 4'hF) wrap_seen = 1'b1;
      m_pop = m_pop + 4'h1;
      m_count--;
    end
    if (exp_push) begin
      sb.push_back(d);
      m_csum ^= d;
      m_count++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk_state(tag);
  endtask

  task automatic model_reset();
    sb.delete();
    m_count = 0;
    m_pop   = '0;
    m_csum  = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_count"}, 32'(count), 32'h0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_out_data"}, 32'(out_data), 32'h0);
    chk({tag, "_csum"}, 32'(csum), 32'h0);
    chk({tag, "_pop_cnt"}, 32'(pop_cnt), 32'h0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'h1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b0;
    model_reset();
    wrap_seen = 1'b0;
    last_popped = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    chk_reset_outputs("reset");

    // Fill to full, then a refused fifth offer.
    cycle(1'b1, 8'h11, 1'b0, "fill");
    cycle(1'b1, 8'h22, 1'b0, "fill");
    cycle(1'b1, 8'h33, 1'b0, "fill");
    cycle(1'b1, 8'h44, 1'b0, "fill");
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'h0);
    chk("full_out_data", 32'(out_data), 32'h11);
    chk("full_csum", 32'(csum), 32'h44);
    cycle(1'b1, 8'h55, 1'b0, "refuse");
    chk("refuse_count", 32'(count), 32'd4);
    chk("refuse_csum", 32'(csum), 32'h44);

    // Drain four words in order.
    repeat (4) cycle(1'b0, 8'h00, 1'b1, "drain");
    chk("drain_pop_cnt", 32'(pop_cnt), 32'd4);
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'h0);
    chk("drain_out_data", 32'(out_data), 32'h0);
    chk("drain_last", 32'(last_popped), 32'h44);

    // Simultaneous push and pop at count 2.
    cycle(1'b1, 8'h77, 1'b0, "sim");
    cycle(1'b1, 8'h88, 1'b0, "sim");
    cycle(1'b1, 8'h66, 1'b1, "sim");
    chk("sim_count", 32'(count), 32'd2);
    chk("sim_head", 32'(out_data), 32'h88);
    repeat (2) cycle(1'b0, 8'h00, 1'b1, "sim_drain");
    chk("sim_last", 32'(last_popped), 32'h66);

    // Full plus pop: only the pop happens, the held word goes in next cycle.
    cycle(1'b1, 8'hA1, 1'b0, "fp");
    cycle(1'b1, 8'hA2, 1'b0, "fp");
    cycle(1'b1, 8'hA3, 1'b0, "fp");
    cycle(1'b1, 8'hA4, 1'b0, "fp");
    cycle(1'b1, 8'hA5, 1'b1, "fp_pop");
    chk("fp_count", 32'(count), 32'd3);
    chk("fp_in_ready", 32'(in_ready), 32'h1);
    cycle(1'b1, 8'hA5, 1'b0, "fp_accept");
    chk("fp_accept_count", 32'(count), 32'd4);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 1000; i++) begin
      cycle(1'(($urandom % 8) < 5), 8'($urandom), 1'(($urandom % 8) < 4), "rand");
    end
    chk("rand_wrap_seen", 32'(wrap_seen), 32'h1);

    // Bring occupancy to exactly 3, then reset mid-stream.
    while (m_count > 0) cycle(1'b0, 8'h00, 1'b1, "pre_rst");
    cycle(1'b1, 8'hC1, 1'b0, "pre_rst");
    cycle(1'b1, 8'hC2, 1'b0, "pre_rst");
    cycle(1'b1, 8'hC3, 1'b0, "pre_rst");
    chk("pre_rst_count", 32'(count), 32'd3);
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    chk_reset_outputs("mid_rst");
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    cycle(1'b1, 8'h5A, 1'b0, "post_rst");
    chk("post_rst_head", 32'(out_data), 32'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
